// File: rtl/instruction_fetch.sv
// Fetch front-end: owns the PC, runs the single-outstanding instruction-memory read
// handshake and buffers {pc, instr} pairs in a first-word-fall-through FIFO.
module instruction_fetch #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h40000060
) (
    input  logic        clk,
    input  logic        reset_n,
    // Instruction memory
    input  logic        instr_mem_resp,
    input  logic [31:0] instr_mem_rdata,
    output logic        instr_read,
    output logic [31:0] instr_mem_address,
    // Instruction queue
    input  logic        iq_dequeue,
    output logic        iq_valid,
    output logic [31:0] iq_instr,
    output logic [31:0] iq_pc,
    // Redirect from the ROB
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDiscard
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_pc;
    logic [31:0]       w_pc_next;
    logic [31:0]       r_addr;
    logic [31:0]       w_addr_next;
    logic              r_read;
    logic              w_read_next;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_enq;
    logic              w_deq;
    logic              w_empty;
    logic [31:0]       w_pc_plus4;

    logic [31:0]       r_mem_instr [DEPTH];
    logic [31:0]       r_mem_pc    [DEPTH];

    assign w_empty    = (r_count == '0);
    assign w_pc_plus4 = r_pc + 32'd4;

    // A response only lands in the FIFO when it belongs to a live request.
    assign w_enq = (r_state == StReq) && instr_mem_resp && !flush;
    assign w_deq = iq_dequeue && !w_empty && !flush;

    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = '0;
        end else begin
            w_count_next = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end

    always_comb begin
        w_pc_next = r_pc;
        if (flush) begin
            w_pc_next = flush_pc;
        end else if (w_enq) begin
            w_pc_next = w_pc_plus4;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        case (r_state)
            StIdle: begin
                if (!flush && (r_count < FULL_CNT)) begin
                    w_state_next = StReq;
                    w_addr_next  = r_pc;
                end
            end
            StReq: begin
                if (instr_mem_resp) begin
                    if (flush) begin
                        w_state_next = StIdle;
                    end else if (w_count_next < FULL_CNT) begin
                        w_addr_next = w_pc_plus4;
                    end else begin
                        w_state_next = StIdle;
                    end
                end else if (flush) begin
                    // Address must stay put until the memory answers the old request.
                    w_state_next = StDiscard;
                end
            end
            StDiscard: begin
                if (instr_mem_resp) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
        w_read_next = (w_state_next != StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_read  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_addr  <= w_addr_next;
            r_read  <= w_read_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
            if (flush) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                r_head <= r_head + PTR_W'(w_deq);
                r_tail <= r_tail + PTR_W'(w_enq);
            end
        end
    end

    // Storage needs no reset; entries are only observed when the count says they are live.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_instr[r_tail] <= instr_mem_rdata;
            r_mem_pc[r_tail]    <= r_pc;
        end
    end

    assign instr_read        = r_read;
    assign instr_mem_address = r_addr;
    assign iq_valid          = !w_empty;
    assign iq_instr          = w_empty ? 32'h0 : r_mem_instr[r_head];
    assign iq_pc             = w_empty ? 32'h0 : r_mem_pc[r_head];

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by random traffic,
// all compared against a transaction-level model built from a queue of {pc, instr} entries.
module tb_instruction_fetch;

    localparam int unsigned DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h40000060;

    logic        clk;
    logic        reset_n;
    logic        instr_mem_resp;
    logic [31:0] instr_mem_rdata;
    logic        instr_read;
    logic [31:0] instr_mem_address;
    logic        iq_dequeue;
    logic        iq_valid;
    logic [31:0] iq_instr;
    logic [31:0] iq_pc;
    logic        flush;
    logic [31:0] flush_pc;

    instruction_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .instr_mem_resp    (instr_mem_resp),
        .instr_mem_rdata   (instr_mem_rdata),
        .instr_read        (instr_read),
        .instr_mem_address (instr_mem_address),
        .iq_dequeue        (iq_dequeue),
        .iq_valid          (iq_valid),
        .iq_instr          (iq_instr),
        .iq_pc             (iq_pc),
        .flush             (flush),
        .flush_pc          (flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Reference model: fetched-but-not-consumed entries, the outstanding request, and the PC.
    ent_t        m_q[$];
    bit          m_req;
    bit          m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_addr;

    int tests;
    int fails;

    task automatic model_reset();
        m_q.delete();
        m_req  = 1'b0;
        m_drop = 1'b0;
        m_pc   = RESET_PC;
        m_addr = RESET_PC;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".read"}, 32'(instr_read), 32'(m_req));
        if (m_req) chk({tag, ".addr"}, instr_mem_address, m_addr);
        chk({tag, ".valid"}, 32'(iq_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk({tag, ".instr"}, iq_instr, m_q[0].instr);
            chk({tag, ".pc"}, iq_pc, m_q[0].pc);
        end
    endtask

    task automatic model_update(input bit resp, input logic [31:0] rdata, input bit deq,
                                input bit fl, input logic [31:0] fpc);
        int          sz;
        bit          enq;
        bit          dq;
        logic [31:0] old_pc;
        sz     = m_q.size();
        enq    = m_req && !m_drop && resp && !fl;
        dq     = deq && (sz > 0) && !fl;
        old_pc = m_pc;
        if (fl) begin
            m_q.delete();
            m_pc = fpc;
        end else begin
            if (dq) void'(m_q.pop_front());
            if (enq) begin
                m_q.push_back('{pc: m_addr, instr: rdata});
                m_pc = old_pc + 32'd4;
            end
        end
        if (!m_req) begin
            if (!fl && (sz < DEPTH)) begin
                m_req  = 1'b1;
                m_addr = old_pc;
            end
        end else if (m_drop) begin
            if (resp) begin
                m_req  = 1'b0;
                m_drop = 1'b0;
            end
        end else if (resp) begin
            if (fl) m_req = 1'b0;
            else if (m_q.size() < DEPTH) m_addr = m_pc;
            else m_req = 1'b0;
        end else if (fl) begin
            m_drop = 1'b1;
        end
    endtask

    // Called at a falling edge: drive one cycle of inputs, clock it, check at the next fall.
    task automatic step(input string tag, input bit resp, input logic [31:0] rdata,
                        input bit deq, input bit fl, input logic [31:0] fpc);
        instr_mem_resp  = resp;
        instr_mem_rdata = rdata;
        iq_dequeue      = deq;
        flush           = fl;
        flush_pc        = fpc;
        model_update(resp, rdata, deq, fl, fpc);
        @(posedge clk);
        @(negedge clk);
        instr_mem_resp = 1'b0;
        iq_dequeue     = 1'b0;
        flush          = 1'b0;
        check_all(tag);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".read"}, 32'(instr_read), 32'd0);
        chk({tag, ".addr"}, instr_mem_address, RESET_PC);
        chk({tag, ".valid"}, 32'(iq_valid), 32'd0);
        chk({tag, ".instr"}, iq_instr, 32'd0);
        chk({tag, ".pc"}, iq_pc, 32'd0);
    endtask

    initial begin
        logic [31:0] prev_pc;
        logic [31:0] r;
        logic [31:0] fpc;
        bit          rsp;
        bit          dq;
        bit          fl;

        tests           = 0;
        fails           = 0;
        instr_mem_resp  = 1'b0;
        instr_mem_rdata = 32'h0;
        iq_dequeue      = 1'b0;
        flush           = 1'b0;
        flush_pc        = 32'h0;
        reset_n         = 1'b1;
        model_reset();
        #1 reset_n = 1'b0;
        #2 check_reset_values("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // First fetch: request at RESET_PC, response two cycles in.
        step("t1.issue", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t1.read_first", 32'(instr_read), 32'd1);
        chk("t1.addr_first", instr_mem_address, 32'h40000060);
        step("t1.wait", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step("t1.resp", 1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0);
        chk("t1.valid", 32'(iq_valid), 32'd1);
        chk("t1.instr", iq_instr, 32'h00000013);
        chk("t1.pc", iq_pc, 32'h40000060);
        chk("t1.next_addr", instr_mem_address, 32'h40000064);

        // Fill to DEPTH with back-to-back responses; request drops when full.
        for (int i = 0; i < 7; i++) step("t2.fill", 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        chk("t2.read_full", 32'(instr_read), 32'd0);
        chk("t2.head_pc", iq_pc, 32'h40000060);
        step("t2.deq", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step("t2.reissue", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t2.read_again", 32'(instr_read), 32'd1);
        chk("t2.addr_again", instr_mem_address, 32'h40000080);

        // Flush while a request waits: old address held, response dropped.
        step("t3.flush", 1'b0, 32'h0, 1'b0, 1'b1, 32'h40000100);
        chk("t3.valid_flushed", 32'(iq_valid), 32'd0);
        chk("t3.addr_held", instr_mem_address, 32'h40000080);
        step("t3.wait1", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step("t3.wait2", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step("t3.resp", 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        chk("t3.dropped", 32'(iq_valid), 32'd0);
        step("t3.reissue", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t3.new_addr", instr_mem_address, 32'h40000100);

        // Flush and dequeue together with three entries buffered.
        for (int i = 0; i < 3; i++) step("t4.fill", 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        chk("t4.valid3", 32'(iq_valid), 32'd1);
        step("t4.flush_deq", 1'b0, 32'h0, 1'b1, 1'b1, 32'h40000200);
        chk("t4.valid0", 32'(iq_valid), 32'd0);
        step("t4.resp", 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        step("t4.reissue", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t4.new_addr", instr_mem_address, 32'h40000200);

        // Steady state: one in, one out every cycle; head PC marches by 4.
        step("t5.prime", 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            prev_pc = iq_pc;
            step("t5.stream", 1'b1, $urandom, 1'b1, 1'b0, 32'h0);
            chk("t5.valid", 32'(iq_valid), 32'd1);
            chk("t5.pc_inc", iq_pc, prev_pc + 32'd4);
        end

        // Asynchronous reset in the middle of a request with five entries buffered.
        step("t6.drain", 1'b0, 32'h0, 1'b0, 1'b1, 32'h40000300);
        step("t6.resp", 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        step("t6.issue", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) step("t6.fill", 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        chk("t6.read_busy", 32'(instr_read), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_values("t6.async");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        check_all("t6.released");

        // Random traffic, including redirects near the top of the address space.
        for (int i = 0; i < 600; i++) begin
            rsp = m_req && ($urandom_range(99) < 60);
            dq  = ($urandom_range(99) < 35);
            fl  = ($urandom_range(99) < 4);
            r   = $urandom;
            fpc = ($urandom_range(3) == 0) ? 32'hFFFFFFF8 : (r & 32'hFFFFFFFC);
            step("rand", rsp, $urandom, dq, fl, fpc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench did not terminate");
    end

endmodule
